unified_mem_ctrl: RTL and testbench
===================================

UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 262144: total words in the unified array (1 MB at WIDTH=32).
REQ-003 Parameter DATA_BASE, default 16384: first word of the data region; words below it form the instruction region.
REQ-004 Parameter LATENCY, default 2, legal range 1..4: cycles from grant to response.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 i_req  in  1  instruction fetch request; held until i_gnt.
REQ-008 i_addr  in  32  instruction word address, absolute.
REQ-009 i_gnt  out  1  instruction request accepted this cycle.
REQ-010 i_rvalid  out  1  one-cycle pulse; i_rdata valid.
REQ-011 i_rdata  out  WIDTH  fetched word.
REQ-012 d_req  in  1  data request; held until d_gnt.
REQ-013 d_we  in  1  1 = write, 0 = read.
REQ-014 d_ins_sel  in  1  1 = address is absolute (loader access to instruction region); 0 = relative to DATA_BASE.
REQ-015 d_addr  in  32  data word address.
REQ-016 d_be  in  WIDTH/8  byte enables for writes; ignored on reads.
REQ-017 d_wdata  in  WIDTH  write data.
REQ-018 d_gnt  out  1  data request accepted this cycle.
REQ-019 d_rvalid  out  1  one-cycle pulse; read data valid or write acknowledged.
REQ-020 d_rdata  out  WIDTH  read word; 0 on write acknowledge.
REQ-021 err  out  1  qualifies the concurrent i_rvalid/d_rvalid pulse as an out-of-range access (REQ-033).

Function
REQ-022 FSM states: IDLE, BUSY; one transaction outstanding at a time.
REQ-023 In IDLE with any request pending, the controller SHALL assert exactly one grant combinationally in that cycle and enter BUSY.
REQ-024 When i_req and d_req are both asserted, the grant SHALL go to the port not granted last; after reset, last grant = data, so instruction wins the first tie.
REQ-025 Effective address: i_addr for instruction; d_ins_sel ? d_addr : DATA_BASE + d_addr for data; sum computed in 32 bits.
REQ-026 Address, we, be and wdata SHALL be registered at the grant edge; requester inputs are don't-care afterwards.
REQ-027 A latency counter SHALL load LATENCY-1 on grant and decrement in BUSY; the response is issued when the counter reaches 0, so the grant in cycle T yields rvalid in cycle T+LATENCY.
REQ-028 On the response cycle: reads SHALL return the array word; writes SHALL update only the bytes whose be bit is 1, at the end of that cycle.
REQ-029 The FSM SHALL return to IDLE in the response cycle; a new grant is possible in the following cycle, giving LATENCY+1 cycles per transaction back-to-back.
REQ-030 A read of an address written by the immediately preceding transaction SHALL return the new data.
REQ-031 No grant SHALL be asserted while in BUSY, even if requests are pending.

Reset
REQ-032 While rst_n=0 at a clock edge: state <- IDLE, counter <- 0, last-grant <- data; i_gnt, d_gnt, i_rvalid, d_rvalid and err <- 0; i_rdata and d_rdata <- 0. A reset arriving mid-transaction SHALL abort it with no response and no array write. Array contents are not reset.

Configuration
REQ-033 With MEM_BOUNDS_CHECK_EN defined, an access is out of range in these cases:
- instruction fetch at address >= DATA_BASE;
- data access with d_ins_sel=0 and d_addr >= DEPTH-DATA_BASE;
- any effective address >= DEPTH.
Such an access SHALL still complete at T+LATENCY with err=1, rdata=0 and no write.
REQ-034 Without MEM_BOUNDS_CHECK_EN, effective addresses SHALL wrap modulo DEPTH and err SHALL be tied to 0.

Structure
REQ-035 Package mem_pkg SHALL hold the default WIDTH/DEPTH/DATA_BASE constants, the FSM state enum and the port-select enum (PORT_INS, PORT_DATA).
REQ-036 One sub-module, mem_rr_arbiter (2-way round-robin with last-grant register), SHALL be instantiated. The array and datapath SHALL be inline.

Verification
REQ-037 Write 0xDEADBEEF, be=1111, to data addr 5; then read data addr 5 -> d_rvalid two cycles after each grant, d_rdata=0xDEADBEEF.
REQ-038 Loader write with d_ins_sel=1, addr 3, 0x00000013; then instruction fetch at addr 3 -> i_rdata=0x00000013.
REQ-039 i_req and d_req both held for 6 transactions -> grants alternate I,D,I,D,I,D starting with instruction; no grants while BUSY.
REQ-040 Word 0x11223344 at data addr 7; write 0xAABBCCDD with be=0101; read addr 7 -> 0x11BB33DD.
REQ-041 With MEM_BOUNDS_CHECK_EN, fetch at addr 16384 -> i_rvalid with err=1, i_rdata=0. Without it, DATA_BASE=0 and DEPTH=1024: a read of d_addr 1029 returns word 5.
REQ-042 Assert rst_n=0 for one cycle one cycle after granting a write of 0x55 to addr 9 -> no d_rvalid; a subsequent read of addr 9 returns the prior value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the unified instruction/data memory controller.
package mem_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 262144;
  localparam int DEF_DATA_BASE = 16384;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  typedef enum logic {PORT_INS, PORT_DATA} port_e;

  // Transaction captured at the grant edge; be/wdata are width-dependent and kept beside it
  typedef struct packed {
    port_e       port;
    logic        we;
    logic        err;
    logic [31:0] addr;
  } req_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter: on a tie the port not granted last wins.
module mem_rr_arbiter
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_i,
  output logic gnt_d
);

  port_e last_q;

  // Grant is combinational so the requester sees it in the request cycle
  always_comb begin
    gnt_i = en & req_i & (~req_d | (last_q == PORT_DATA));
    gnt_d = en & req_d & (~req_i | (last_q == PORT_INS));
  end

  // Remember the last winner; reset favours instruction on the first tie
  always_ff @(posedge clk) begin
    if (!rst_n)     last_q <= PORT_DATA;
    else if (gnt_i) last_q <= PORT_INS;
    else if (gnt_d) last_q <= PORT_DATA;
  end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory controller: one array, two requesters,
// one transaction in flight, fixed grant-to-response latency.
// Optional MEM_BOUNDS_CHECK_EN: flag out-of-range accesses with err instead
// of wrapping the address modulo DEPTH.
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DATA_BASE = DEF_DATA_BASE,
  parameter int LATENCY   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req,
  input  logic [31:0]        i_addr,
  output logic               i_gnt,
  output logic               i_rvalid,
  output logic [WIDTH-1:0]   i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic               d_ins_sel,
  input  logic [31:0]        d_addr,
  input  logic [WIDTH/8-1:0] d_be,
  input  logic [WIDTH-1:0]   d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [WIDTH-1:0]   d_rdata,
  output logic               err
);

  localparam int         BW     = WIDTH / 8;
  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  state_e           state;
  logic [2:0]       cnt;
  req_t             cur, nxt, rd_src;
  logic [BW-1:0]    be_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word;
  logic [31:0]      d_eff;
  logic             any_gnt, resp_next, resp_now;

  function automatic logic [AW-1:0] to_idx(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return AW'(a);
`else
    return AW'(a % 32'(DEPTH));
`endif
  endfunction

  mem_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rst_n && state == S_IDLE),
    .req_i (i_req),
    .req_d (d_req),
    .gnt_i (i_gnt),
    .gnt_d (d_gnt)
  );

  assign any_gnt = i_gnt | d_gnt;

  // Build the transaction that the current grant would capture, incl. range check
  always_comb begin
    d_eff    = d_ins_sel ? d_addr : 32'(DATA_BASE) + d_addr;
    nxt      = '0;
    nxt.port = d_gnt ? PORT_DATA : PORT_INS;
    nxt.we   = d_gnt & d_we;
    nxt.addr = d_gnt ? d_eff : i_addr;
`ifdef MEM_BOUNDS_CHECK_EN
    nxt.err  = d_gnt ? ((!d_ins_sel && d_addr >= 32'(DEPTH - DATA_BASE)) || d_eff >= 32'(DEPTH))
                     : (i_addr >= 32'(DATA_BASE) || i_addr >= 32'(DEPTH));
`else
    nxt.err  = 1'b0;
`endif
  end

  // Outputs are registered, so the response is prepared one edge early.
  // With LATENCY=1 that edge is the grant edge itself, hence the live-request source.
  always_comb begin
    resp_next = (state == S_IDLE && any_gnt && LATENCY == 1) ||
                (state == S_BUSY && cnt == 3'd1);
    resp_now  = (state == S_BUSY && cnt == 3'd0);
    rd_src    = (state == S_IDLE) ? nxt : cur;
    rd_word   = (!rd_src.we && !rd_src.err) ? mem[to_idx(rd_src.addr)] : '0;
  end

  // Control FSM: capture on grant, count down latency, drive the response pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur      <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      err      <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= resp_next && rd_src.port == PORT_INS;
      d_rvalid <= resp_next && rd_src.port == PORT_DATA;
      err      <= resp_next && rd_src.err;
      i_rdata  <= (resp_next && rd_src.port == PORT_INS)  ? rd_word : '0;
      d_rdata  <= (resp_next && rd_src.port == PORT_DATA) ? rd_word : '0;
      case (state)
        S_IDLE: if (any_gnt) begin
          cur     <= nxt;
          be_q    <= d_be;
          wdata_q <= d_wdata;
          cnt     <= LAT_M1;
          state   <= S_BUSY;
        end
        S_BUSY: begin
          if (cnt == 3'd0) state <= S_IDLE;
          else             cnt   <= cnt - 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte-masked write lands at the end of the response cycle; a reset aborts it
  always_ff @(posedge clk) begin
    if (rst_n && resp_now && cur.we && !cur.err) begin
      for (int b = 0; b < BW; b++)
        if (be_q[b]) mem[to_idx(cur.addr)][b*8 +: 8] <= wdata_q[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Scoreboard bench for unified_mem_ctrl (DEPTH=1024, DATA_BASE=256, LATENCY=2).
module tb_unified_mem_ctrl;

  localparam int LAT = 2;

  logic        clk = 0, rst_n = 0;
  logic        i_req = 0, d_req = 0, d_we = 0, d_ins_sel = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  d_be = 0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, err;
  logic [31:0] i_rdata, d_rdata;

  unified_mem_ctrl #(.WIDTH(32), .DEPTH(1024), .DATA_BASE(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_ins_sel(d_ins_sel), .d_addr(d_addr), .d_be(d_be),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          e;
    int          gcyc;
  } exp_t;

  exp_t exp_q[$];
  bit   gnt_log[$];
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grant-while-busy check, grant log, and response scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0;
    end else begin
      if (busy > 0) begin
        total++;
        if (i_gnt || d_gnt) begin
          bad++;
          $display("FAIL gnt_while_busy cyc=%0d i_gnt=%0b d_gnt=%0b want 0", cyc, i_gnt, d_gnt);
        end
        busy--;
      end
      if (i_gnt || d_gnt) begin
        gnt_log.push_back(d_gnt);
        busy = LAT;
      end
      if (i_rvalid || d_rvalid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rvalid cyc=%0d i_rvalid=%0b d_rvalid=%0b", cyc, i_rvalid, d_rvalid);
        end else begin
          exp_t e;
          logic [31:0] act;
          e   = exp_q.pop_front();
          act = e.is_d ? d_rdata : i_rdata;
          if ((i_rvalid && d_rvalid) || (d_rvalid != e.is_d) || act !== e.data ||
              err !== e.e || (cyc - e.gcyc) != LAT) begin
            bad++;
            $display("FAIL resp cyc=%0d got port_d=%0b data=%h err=%0b lat=%0d want port_d=%0b data=%h err=%0b lat=%0d",
                     cyc, d_rvalid, act, err, cyc - e.gcyc, e.is_d, e.data, e.e, LAT);
          end
        end
      end
    end
  end

  task automatic issue(input bit is_d, input bit we, input bit sel, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] exp_d, input bit exp_e, input bit want_resp);
    int  n = 0;
    bit  got = 0;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1; d_we = we; d_ins_sel = sel; d_addr = addr; d_be = be; d_wdata = wd;
    end else begin
      i_req = 1; i_addr = addr;
    end
    while (!got && n <= 40) begin
      @(negedge clk);
      if (is_d ? d_gnt : i_gnt) got = 1;
      else n++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL gnt_timeout port_d=%0b addr=%h", is_d, addr);
    end else if (want_resp) begin
      exp_q.push_back('{is_d, exp_d, exp_e, cyc});
    end
    @(posedge clk); #1;
    if (is_d) d_req = 0; else i_req = 0;
  endtask

  task automatic check_quiet(input string name);
    total++;
    if (i_gnt || d_gnt || i_rvalid || d_rvalid || err || i_rdata != 0 || d_rdata != 0) begin
      bad++;
      $display("FAIL %s gnt=%0b%0b rvalid=%0b%0b err=%0b rdata=%h/%h want all 0",
               name, i_gnt, d_gnt, i_rvalid, d_rvalid, err, i_rdata, d_rdata);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_order(input string name, input bit want[$]);
    total++;
    if (gnt_log.size() < want.size()) begin
      bad++;
      $display("FAIL %s grants=%0d want %0d", name, gnt_log.size(), want.size());
    end else begin
      for (int k = 0; k < want.size(); k++)
        if (gnt_log[k] != want[k]) begin
          bad++;
          $display("FAIL %s grant%0d port_d=%0b want %0b", name, k, gnt_log[k], want[k]);
          break;
        end
    end
  endtask

  initial begin
    // Reset with requests pending: nothing may be granted or returned
    i_req = 1; d_req = 1;
    repeat (3) @(negedge clk);
    check_quiet("reset_state");
    i_req = 0; d_req = 0;
    @(posedge clk); #1 rst_n = 1;

    // Full write then read-back at data addr 5
    issue(1, 1, 0, 5, 4'hF, 32'hDEADBEEF, 32'h0, 0, 1);
    issue(1, 0, 0, 5, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1);
    drain();

    // Loader write into instruction region, then fetch it
    issue(1, 1, 1, 3, 4'hF, 32'h00000013, 32'h0, 0, 1);
    issue(0, 0, 0, 3, 4'h0, 32'h0, 32'h00000013, 0, 1);
    drain();

    // Byte-masked merge
    issue(1, 1, 0, 7, 4'hF, 32'h11223344, 32'h0, 0, 1);
    issue(1, 1, 0, 7, 4'b0101, 32'hAABBCCDD, 32'h0, 0, 1);
    issue(1, 0, 0, 7, 4'hF, 32'h0, 32'h11BB33DD, 0, 1);
    drain();

    // Contention: six transactions alternate starting with instruction
    gnt_log.delete();
    fork
      begin
        for (int k = 0; k < 3; k++) issue(0, 0, 0, 3, 4'h0, 32'h0, 32'h00000013, 0, 1);
      end
      begin
        for (int k = 0; k < 3; k++) issue(1, 0, 0, 7, 4'h0, 32'h0, 32'h11BB33DD, 0, 1);
      end
    join
    drain();
    check_order("rr_alternate", '{0, 1, 0, 1, 0, 1});

`ifdef MEM_BOUNDS_CHECK_EN
    // Fetch at the data region boundary is flagged and returns zero
    issue(0, 0, 0, 256, 4'h0, 32'h0, 32'h0, 1, 1);
    issue(1, 0, 0, 1029, 4'h0, 32'h0, 32'h0, 1, 1);
    drain();
`else
    // Relative 1029 + base 256 = 1285 wraps to word 261 (data addr 5)
    issue(1, 0, 0, 1029, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1);
    drain();
`endif

    // Last-grant resets to data: after an instruction grant and a reset, instruction still wins a tie
    issue(0, 0, 0, 3, 4'h0, 32'h0, 32'h00000013, 0, 1);
    drain();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    gnt_log.delete();
    fork
      issue(0, 0, 0, 3, 4'h0, 32'h0, 32'h00000013, 0, 1);
      issue(1, 0, 0, 7, 4'h0, 32'h0, 32'h11BB33DD, 0, 1);
    join
    drain();
    check_order("rr_after_reset", '{0, 1});

    // Reset one cycle after granting a write aborts it
    issue(1, 1, 0, 9, 4'hF, 32'hCAFEF00D, 32'h0, 0, 1);
    drain();
    issue(1, 1, 0, 9, 4'hF, 32'h00000055, 32'h0, 0, 0);
    rst_n = 0;
    @(negedge clk);
    check_quiet("abort_reset");
    @(posedge clk); #1 rst_n = 1;
    repeat (4) @(negedge clk);
    issue(1, 0, 0, 9, 4'h0, 32'h0, 32'hCAFEF00D, 0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
